// File: rtl/alu_sequencer.sv
// alu_sequencer: accepts one command at a time and turns its opcode into
// control words for an external 16-bit combinational ALU. Multiply is built
// from 16 shift-and-add passes through the same ALU. Each result and its flags
// are returned over a valid/ready response handshake.
module alu_sequencer (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [2:0]  cmd_op_i,
  input  logic [15:0] cmd_a_i,
  input  logic [15:0] cmd_b_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [15:0] rsp_data_o,
  output logic        rsp_zr_o,
  output logic        rsp_ng_o,
  output logic        rsp_err_o,
  output logic [15:0] alu_x_o,
  output logic [15:0] alu_y_o,
  output logic        alu_zx_o,
  output logic        alu_nx_o,
  output logic        alu_zy_o,
  output logic        alu_ny_o,
  output logic        alu_f_o,
  output logic        alu_no_o,
  input  logic [15:0] alu_o_i,
  input  logic        alu_zr_i,
  input  logic        alu_ng_i
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_e;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_MUL = 3'd4;
  localparam logic [2:0] OP_CMP = 3'd5;

  // ALU control words, ordered {zx, nx, zy, ny, f, no}.
  localparam logic [5:0] CTRL_AND  = 6'b000000;
  localparam logic [5:0] CTRL_OR   = 6'b010101;
  localparam logic [5:0] CTRL_ADD  = 6'b000010;
  localparam logic [5:0] CTRL_SUB  = 6'b010011;
  localparam logic [5:0] CTRL_PASS = 6'b001010;

  state_e      state_q, state_d;
  logic [2:0]  op_q;
  logic [15:0] a_q, b_q;
  logic [15:0] acc_q, mcand_q, mplier_q;
  logic [3:0]  cnt_q;
  logic [15:0] rsp_data_q;
  logic        rsp_zr_q, rsp_ng_q, rsp_err_q;
  logic [5:0]  alu_ctrl;
  logic        op_illegal;

  // Opcodes 6 and 7 are the only ones with both upper bits set.
  assign op_illegal = op_q[2] & op_q[1];

  assign {alu_zx_o, alu_nx_o, alu_zy_o, alu_ny_o, alu_f_o, alu_no_o} = alu_ctrl;
  assign rsp_data_o = rsp_data_q;
  assign rsp_zr_o   = rsp_zr_q;
  assign rsp_ng_o   = rsp_ng_q;
  assign rsp_err_o  = rsp_err_q;

  // Next-state decode plus handshake and ALU drive for the current state.
  always_comb begin
    // NOTE: every output gets a default before the case, so no path can leave
    // a signal unassigned and infer a latch.
    state_d     = state_q;
    cmd_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    alu_x_o     = '0;
    alu_y_o     = '0;
    alu_ctrl    = '0;
    case (state_q)
      S_IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) state_d = (cmd_op_i == OP_MUL) ? S_MUL : S_EXEC;
      end
      S_EXEC: begin
        alu_x_o = a_q;
        alu_y_o = b_q;
        case (op_q)
          OP_AND:         alu_ctrl = CTRL_AND;
          OP_OR:          alu_ctrl = CTRL_OR;
          OP_SUB, OP_CMP: alu_ctrl = CTRL_SUB;
          default:        alu_ctrl = CTRL_ADD;
        endcase
        state_d = S_DONE;
      end
      S_MUL: begin
        alu_x_o  = acc_q;
        alu_y_o  = mcand_q;
        alu_ctrl = mplier_q[0] ? CTRL_ADD : CTRL_PASS;
        if (cnt_q == 4'd15) state_d = S_DONE;
      end
      S_DONE: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples values from before the edge, independent of statement order.
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Command latch, multiply iteration registers and response capture.
  always_ff @(posedge clk_i or posedge reset_i) begin
    // NOTE: every register here has a reset value because the response
    // outputs must read zero immediately after reset.
    if (reset_i) begin
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      rsp_zr_q   <= 1'b0;
      rsp_ng_q   <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid_i) begin
            op_q     <= cmd_op_i;
            a_q      <= cmd_a_i;
            b_q      <= cmd_b_i;
            acc_q    <= '0;
            mcand_q  <= cmd_a_i;
            mplier_q <= cmd_b_i;
            cnt_q    <= '0;
          end
        end
        S_EXEC: begin
          rsp_data_q <= (op_q == OP_CMP || op_illegal) ? 16'h0000 : alu_o_i;
          rsp_zr_q   <= alu_zr_i;
          rsp_ng_q   <= alu_ng_i;
          rsp_err_q  <= op_illegal;
        end
        S_MUL: begin
          acc_q    <= alu_o_i;
          mcand_q  <= {mcand_q[14:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[15:1]};
          cnt_q    <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            rsp_data_q <= alu_o_i;
            rsp_zr_q   <= alu_zr_i;
            rsp_ng_q   <= alu_ng_i;
            rsp_err_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
